// File: rtl/key_debouncer_if.sv
// Key debouncer bundle: raw active-low pins in, registered press/release/level/long out.
// Pins are asynchronous; outputs are single-cycle pulses (level excepted), no backpressure.
interface key_debouncer_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] i_key_n;
    logic [NUM_KEYS-1:0] o_press;
    logic [NUM_KEYS-1:0] o_release;
    logic [NUM_KEYS-1:0] o_level;
    logic [NUM_KEYS-1:0] o_long;

    modport master (
        output i_key_n,
        input  o_press, o_release, o_level, o_long
    );

    modport slave (
        input  i_key_n,
        output o_press, o_release, o_level, o_long
    );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-flop sync + debounce FSM with press/release/long pulses and a debounced level.
// Latency DEBOUNCE_CYCLES+3 edges from first pin sample; outputs registered, no backpressure.
module key_debouncer #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 24000000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    key_debouncer_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t              state    [NUM_KEYS];
    logic [CW-1:0]       cnt      [NUM_KEYS];
    logic [HW-1:0]       hold_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_fired;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] release_q;
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] long_q;
    logic [NUM_KEYS-1:0] pressed;

    assign pressed = ~sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.i_key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k]    <= IDLE;
                cnt[k]      <= '0;
                hold_cnt[k] <= '0;
            end
            long_fired <= '0;
            press_q    <= '0;
            release_q  <= '0;
            level_q    <= '0;
            long_q     <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                press_q[k]   <= 1'b0;
                release_q[k] <= 1'b0;
                long_q[k]    <= 1'b0;

                // Hold timer keeps running through a release check so a bounce does not restart it.
                if (state[k] == HELD || state[k] == REL_CHK) begin
                    if (hold_cnt[k] != HOLD_MAX) begin
                        hold_cnt[k] <= hold_cnt[k] + HW'(1);
                    end else if (!long_fired[k]) begin
                        long_q[k]     <= 1'b1;
                        long_fired[k] <= 1'b1;
                    end
                end

                case (state[k])
                    IDLE: begin
                        if (pressed[k]) begin
                            state[k] <= PRESS_CHK;
                            cnt[k]   <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!pressed[k]) begin
                            state[k] <= IDLE;
                        end else if (cnt[k] == CNT_MAX) begin
                            state[k]      <= HELD;
                            press_q[k]    <= 1'b1;
                            level_q[k]    <= 1'b1;
                            hold_cnt[k]   <= '0;
                            long_fired[k] <= 1'b0;
                        end else begin
                            cnt[k] <= cnt[k] + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!pressed[k]) begin
                            state[k] <= REL_CHK;
                            cnt[k]   <= '0;
                        end
                    end
                    REL_CHK: begin
                        if (pressed[k]) begin
                            state[k] <= HELD;
                        end else if (cnt[k] == CNT_MAX) begin
                            state[k]     <= IDLE;
                            release_q[k] <= 1'b1;
                            level_q[k]   <= 1'b0;
                        end else begin
                            cnt[k] <= cnt[k] + CW'(1);
                        end
                    end
                    default: state[k] <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_level   = level_q;
    assign bus.o_long    = long_q;
endmodule
